// File: rtl/ram16k_arbiter_if.sv
// ----------------------------------------------------------------------------
// ram16k_arbiter_if
// Bundles the two requester ports and the RAM16K pins that the arbiter sits
// between.
//   req0/req1, we0/we1, addr0/addr1, wdata0/wdata1 : requester -> arbiter
//   ack0/ack1, rdata0/rdata1, busy, gnt            : arbiter -> requesters
//   ram_in, ram_load, ram_address                  : arbiter -> RAM
//   ram_out                                        : RAM -> arbiter
// The slave modport is the arbiter's view. The master modport is the view of
// the requesters and the RAM.
// ----------------------------------------------------------------------------
interface ram16k_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16
);
    logic              req0, req1;
    logic              we0, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              ack0, ack1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic              busy;
    logic              gnt;
    logic [DATA_W-1:0] ram_in;
    logic              ram_load;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_out;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_out,
        output ack0, ack1, rdata0, rdata1, busy, gnt,
               ram_in, ram_load, ram_address
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_out,
        input  ack0, ack1, rdata0, rdata1, busy, gnt,
               ram_in, ram_load, ram_address
    );
endinterface

// File: rtl/ram16k_arbiter.sv
// ----------------------------------------------------------------------------
// ram16k_arbiter
// Round-robin arbiter and sequencer that shares one RAM16K between two
// requesters. The arbiter latches the winning request and drives the RAM for
// one ACCESS cycle. It captures read data on the edge that ends ACCESS, then
// pulses ack for the winning port during DONE.
// Ports:
//   clock   : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : requester and RAM signals (slave modport of ram16k_arbiter_if)
// ----------------------------------------------------------------------------
module ram16k_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    ram16k_arbiter_if.slave        bus
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

    state_e            state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              win;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            gnt_q    <= 1'b1;   // port 0 takes the first tie
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        // On a tie the port that was not granted last wins. Otherwise the lone
        // requester wins.
        win      = (bus.req0 && bus.req1) ? ~gnt_q : bus.req1;
        unique case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    state_d = ACCESS;
                    gnt_d   = win;
                    we_d    = win ? bus.we1    : bus.we0;
                    addr_d  = win ? bus.addr1  : bus.addr0;
                    wdata_d = win ? bus.wdata1 : bus.wdata0;
                end
            end
            ACCESS: begin
                state_d = DONE;
                if (!we_q) begin
                    if (gnt_q) rdata1_d = bus.ram_out;
                    else       rdata0_d = bus.ram_out;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The latched address and data registers also drive the RAM pins. They
    // change only when a request is taken, so the pins hold their last values
    // outside ACCESS. ram_load is decoded from state. An asynchronous reset
    // therefore kills a pending write before the next edge.
    assign bus.ram_address = addr_q;
    assign bus.ram_in      = wdata_q;
    assign bus.ram_load    = (state_q == ACCESS) && we_q;
    assign bus.ack0        = (state_q == DONE) && !gnt_q;
    assign bus.ack1        = (state_q == DONE) &&  gnt_q;
    assign bus.rdata0      = rdata0_q;
    assign bus.rdata1      = rdata1_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.gnt         = gnt_q;

endmodule

// File: tb/tb_ram16k_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ram16k_arbiter
// Directed bench for ram16k_arbiter. A behavioural RAM16K has a combinational
// read and writes on the rising clock edge when load is high. Inputs change
// and outputs are sampled 1 time unit after each rising edge.
// ----------------------------------------------------------------------------
module tb_ram16k_arbiter;

    logic clock;
    logic reset_n;

    ram16k_arbiter_if #(.ADDR_W(14), .DATA_W(16)) bus ();

    ram16k_arbiter #(.ADDR_W(14), .DATA_W(16)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    logic [15:0] mem [0:16383];
    assign bus.ram_out = mem[bus.ram_address];
    always @(posedge clock) if (bus.ram_load) mem[bus.ram_address] <= bus.ram_in;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_chk;
    int n_fail;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        repeat (2) tick();
        reset_n  = 1'b1;
    endtask

    int grants [4];
    int n_ack;
    int lat;
    int r0start;
    int cyc;

    initial begin
        n_chk = 0; n_fail = 0;
        for (int i = 0; i < 16384; i++) mem[i] = '0;
        bus.we0 = 0; bus.we1 = 0; bus.addr0 = '0; bus.addr1 = '0;
        bus.wdata0 = '0; bus.wdata1 = '0;

        // Hold reset for 3 cycles while port 0 requests a write.
        reset_n = 1'b0; bus.req1 = 1'b0;
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 14'd5; bus.wdata0 = 16'd3;
        #1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_load", bus.ram_load, 0);
            chk("rst_busy", bus.busy, 0);
        end
        chk("rst_gnt",   bus.gnt, 1);
        chk("rst_ack",   {bus.ack0, bus.ack1}, 0);
        chk("rst_rdata", {bus.rdata0, bus.rdata1}, 0);
        chk("rst_addr",  bus.ram_address, 0);
        chk("rst_in",    bus.ram_in, 0);
        chk("rst_mem5",  mem[5], 0);

        // Port 0 writes 3 to address 5, then reads it back.
        reset_n = 1'b1;
        tick();
        chk("w0_load",   bus.ram_load, 1);
        chk("w0_addr",   bus.ram_address, 5);
        chk("w0_in",     bus.ram_in, 3);
        chk("w0_gnt",    bus.gnt, 0);
        chk("w0_busy",   bus.busy, 1);
        tick();
        chk("w0_ack",    {bus.ack0, bus.ack1}, 2'b10);
        chk("w0_done_load", bus.ram_load, 0);
        chk("w0_rdata0", bus.rdata0, 0);
        bus.req0 = 1'b0;
        tick();
        chk("w0_idle",   {bus.busy, bus.ack0}, 0);
        chk("w0_mem5",   mem[5], 3);
        bus.req0 = 1'b1; bus.we0 = 1'b0;
        tick();
        chk("r0_load",   bus.ram_load, 0);
        chk("r0_addr",   bus.ram_address, 5);
        tick();
        chk("r0_ack",    bus.ack0, 1);
        chk("r0_rdata0", bus.rdata0, 3);
        chk("r0_rdata1", bus.rdata1, 0);
        bus.req0 = 1'b0;
        tick();

        // Both ports request together after reset. Port 0 writes 7 to address
        // 10, then port 1 reads address 10.
        do_reset();
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 14'd10; bus.wdata0 = 16'd7;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 14'd10;
        tick();
        chk("tie_gnt0",  bus.gnt, 0);
        chk("tie_load",  bus.ram_load, 1);
        tick();
        chk("tie_ack0",  {bus.ack0, bus.ack1}, 2'b10);
        bus.req0 = 1'b0;
        tick();
        chk("tie_idle",  bus.busy, 0);
        tick();
        chk("tie_gnt1",  bus.gnt, 1);
        chk("tie_addr",  bus.ram_address, 10);
        chk("tie_load1", bus.ram_load, 0);
        tick();
        chk("tie_ack1",  {bus.ack0, bus.ack1}, 2'b01);
        chk("tie_rd1",   bus.rdata1, 7);
        chk("tie_rd0",   bus.rdata0, 0);
        bus.req1 = 1'b0;
        tick();

        // Port 1 requests continuously for 4 transactions. Port 0 requests a
        // read of address 30 while port 1's first write (1 to address 30) is
        // in progress.
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 14'd30; bus.wdata1 = 16'd1;
        n_ack = 0; lat = -1; r0start = 0; cyc = 0;
        for (int c = 0; c < 20 && n_ack < 4; c++) begin
            tick();
            cyc++;
            if (bus.ack0) begin
                grants[n_ack] = 0; n_ack++;
                lat = cyc - r0start;
                bus.req0 = 1'b0;
            end else if (bus.ack1) begin
                grants[n_ack] = 1; n_ack++;
            end
            if (c == 0) begin
                bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 14'd30;
                r0start = cyc;
            end
        end
        bus.req1 = 1'b0;
        chk("rr_count", n_ack, 4);
        chk("rr_g0", grants[0], 1);
        chk("rr_g1", grants[1], 0);
        chk("rr_g2", grants[2], 1);
        chk("rr_g3", grants[3], 1);
        chk("rr_lat", lat, 4);
        chk("rr_rd0", bus.rdata0, 1);
        tick();

        // Changing addr0 after the grant must not affect the access.
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 14'd9; bus.wdata0 = 16'h99;
        tick();
        bus.addr0 = 14'd12;
        chk("lat_addr", bus.ram_address, 9);
        chk("lat_load", bus.ram_load, 1);
        tick();
        chk("lat_ack",  bus.ack0, 1);
        bus.req0 = 1'b0;
        tick();
        chk("lat_mem9",  mem[9], 16'h99);
        chk("lat_mem12", mem[12], 0);
        bus.req0 = 1'b1; bus.we0 = 1'b0;
        repeat (2) tick();
        chk("lat_rd12", bus.rdata0, 0);
        bus.req0 = 1'b0;
        tick();

        // Assert reset while port 1's write of 55 to address 100 is in ACCESS.
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 14'd100; bus.wdata1 = 16'd55;
        tick();
        chk("mid_load_pre", bus.ram_load, 1);
        reset_n = 1'b0;
        #1;
        chk("mid_load", bus.ram_load, 0);
        chk("mid_busy", bus.busy, 0);
        bus.req1 = 1'b0;
        tick();
        chk("mid_ack", {bus.ack0, bus.ack1}, 0);
        chk("mid_mem", mem[100], 0);
        reset_n = 1'b1;
        tick();
        chk("mid_ack2", {bus.ack0, bus.ack1}, 0);
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 14'd100;
        tick();
        chk("mid_gnt", bus.gnt, 1);
        tick();
        chk("mid_rack", bus.ack1, 1);
        chk("mid_rd1",  bus.rdata1, 0);
        bus.req1 = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
